game_countdown_timer: RTL and testbench

- Two-digit BCD countdown timer for the game round; the decrementing counterpart to the tile-collection score counter.
- Loads a preset time on start and decrements one BCD second per prescaled tick. Subtracts penalty seconds on request and flags expiry.
- Outputs lowDigit/highDigit in the same BCD format as the score counter, so the existing digit display path can read them.

---
 rtl/game_countdown_timer_pkg.sv | 18 +
 rtl/game_countdown_timer_if.sv | 15 +
 rtl/game_countdown_timer_sec_tick_gen.sv | 18 +
 rtl/game_countdown_timer.sv | 65 ++++++
 tb/tb_game_countdown_timer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/game_countdown_timer_pkg.sv
// game_timer_pkg: shared state encoding, two-digit BCD type and saturating BCD subtract.
package game_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} t_timer_state;
  typedef struct packed {
    logic [3:0] hi;
    logic [3:0] lo;
  } t_bcd2;
  localparam int MAX_BCD_SEC = 99;
  // Works in binary so digit borrows and the floor at zero come out naturally.
  function automatic t_bcd2 bcd_sub(t_bcd2 v, logic [3:0] amt);
    logic [6:0] b;
    logic [6:0] r;
    b = 7'(v.hi) * 7'd10 + 7'(v.lo);
    r = (b > 7'(amt)) ? b - 7'(amt) : 7'd0;
    r = (r > 7'(MAX_BCD_SEC)) ? 7'(MAX_BCD_SEC) : r;
    return '{hi: 4'(r / 7'd10), lo: 4'(r % 7'd10)};
  endfunction
endpackage

// File: rtl/game_countdown_timer_if.sv
// game_countdown_timer_if: control pulses in, BCD digits and status out.
interface game_countdown_timer_if;
  logic       start;
  logic       pause;
  logic       penalty;
  logic [3:0] lowDigit;
  logic [3:0] highDigit;
  logic       running;
  logic       time_up;
  logic       expired;
  modport master (output start, pause, penalty,
                  input  lowDigit, highDigit, running, time_up, expired);
  modport slave  (input  start, pause, penalty,
                  output lowDigit, highDigit, running, time_up, expired);
endinterface

// File: rtl/game_countdown_timer_sec_tick_gen.sv
// sec_tick_gen: one-cycle tick every TICKS_PER_SEC cycles in which hold is low.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic hold,
  output logic tick
);
  localparam int W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = !clear && !hold && (cnt_q == W'(TICKS_PER_SEC - 1));
  always_comb cnt_d = clear ? '0 : hold ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/game_countdown_timer.sv
// game_countdown_timer: two-digit BCD round timer with pause, penalty and expiry.
module game_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int         TICKS_PER_SEC = 50_000_000,
  parameter logic [3:0] START_HIGH    = 4'd6,
  parameter logic [3:0] START_LOW     = 4'd0,
  parameter logic [3:0] PENALTY_SEC   = 4'd3
) (
  input logic                   clk,
  input logic                   resetN,
  game_countdown_timer_if.slave bus
);
  localparam t_bcd2 START = '{hi: START_HIGH, lo: START_LOW};
  t_timer_state state_q, state_d;
  t_bcd2        digits_q, digits_d, nxt;
  logic         running_q, running_d, time_up_q, time_up_d, expired_q, expired_d;
  logic         active, tick;
  logic [3:0]   amt;
  assign active = (state_q == RUNNING) || (state_q == PAUSED);
  // PAUSED with pause released already counts, so resume costs no cycle.
  sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clk   (clk),
    .resetN(resetN),
    .clear (bus.start),
    .hold  (bus.pause || !active),
    .tick  (tick)
  );
  always_comb begin
    amt       = (tick ? 4'd1 : 4'd0) + (bus.penalty ? PENALTY_SEC : 4'd0);
    nxt       = bcd_sub(digits_q, amt);
    state_d   = state_q;
    digits_d  = digits_q;
    time_up_d = 1'b0;
    if (bus.start) begin
      state_d  = RUNNING;
      digits_d = START;
    end else if (active) begin
      digits_d  = nxt;
      time_up_d = (nxt == '0);
      state_d   = (nxt == '0) ? EXPIRED : bus.pause ? PAUSED : RUNNING;
    end
    running_d = (state_d == RUNNING);
    expired_d = (state_d == EXPIRED);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q   <= IDLE;
      digits_q  <= START;
      running_q <= 1'b0;
      time_up_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      time_up_q <= time_up_d;
      expired_q <= expired_d;
    end
  assign bus.highDigit = digits_q.hi;
  assign bus.lowDigit  = digits_q.lo;
  assign bus.running   = running_q;
  assign bus.time_up   = time_up_q;
  assign bus.expired   = expired_q;
endmodule

// File: tb/tb_game_countdown_timer.sv
// tb_game_countdown_timer: directed scenarios plus random traffic against an integer-seconds model.
module tb_game_countdown_timer;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   m_sec, m_sub;
  bit   m_act, m_frz, m_done, m_pulse;
  game_countdown_timer_if tif();
  game_countdown_timer #(
    .TICKS_PER_SEC(4), .START_HIGH(4'd1), .START_LOW(4'd2), .PENALTY_SEC(4'd3)
  ) dut (.clk(clk), .resetN(resetN), .bus(tif));
  always #5 clk = ~clk;
  function automatic logic [10:0] obs();
    return {tif.highDigit, tif.lowDigit, tif.running, tif.time_up, tif.expired};
  endfunction
  function automatic logic [10:0] expv();
    return {4'(m_sec / 10), 4'(m_sec % 10), m_act && !m_frz, m_pulse, m_done};
  endfunction
  task automatic model_reset();
    m_sec = 12; m_sub = 0; m_act = 0; m_frz = 0; m_done = 0; m_pulse = 0;
  endtask
  // Remaining time in whole seconds; a second elapses after 4 unpaused cycles.
  task automatic model_step(input bit s, input bit p, input bit n);
    int d;
    m_pulse = 0;
    if (s) begin
      m_sec = 12; m_sub = 0; m_act = 1; m_frz = 0; m_done = 0;
    end else if (m_act) begin
      d = n ? 3 : 0;
      if (!p) begin
        m_sub++;
        if (m_sub == 4) begin m_sub = 0; d++; end
      end
      m_sec = (m_sec > d) ? m_sec - d : 0;
      m_frz = p;
      if (m_sec == 0) begin m_act = 0; m_done = 1; m_pulse = 1; end
    end
  endtask
  task automatic cyc(input bit s, input bit p, input bit n);
    tif.start = s; tif.pause = p; tif.penalty = n;
    @(posedge clk);
    model_step(s, p, n);
    #1;
  endtask
  task automatic test_reset();
    tif.start = 0; tif.pause = 0; tif.penalty = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== {4'd1, 4'd2, 3'b000}) begin
      errors++; $display("FAIL reset_state got=%h want=%h", obs(), {4'd1, 4'd2, 3'b000});
    end
    resetN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1);
      checks++;
      if (obs() !== {4'd1, 4'd2, 3'b000}) begin
        errors++; $display("FAIL idle_ignores got=%h want=%h", obs(), {4'd1, 4'd2, 3'b000});
      end
    end
  endtask
  task automatic test_countdown();
    cyc(1, 0, 0);
    checks++;
    if (obs() !== {4'd1, 4'd2, 3'b100}) begin
      errors++; $display("FAIL start_load got=%h want=%h", obs(), {4'd1, 4'd2, 3'b100});
    end
    for (int k = 1; k <= 3; k++) begin
      repeat (4) cyc(0, 0, 0);
      checks++;
      if (obs() !== {4'((12 - k) / 10), 4'((12 - k) % 10), 3'b100}) begin
        errors++; $display("FAIL countdown_%0d got=%h want=%h", k, obs(),
                           {4'((12 - k) / 10), 4'((12 - k) % 10), 3'b100});
      end
    end
  endtask
  task automatic test_expire();
    int pulses = 0;
    cyc(1, 0, 0);
    for (int i = 0; i < 48; i++) begin
      cyc(0, 0, 0);
      if (tif.time_up) pulses++;
    end
    checks++;
    if (obs() !== {4'd0, 4'd0, 3'b011}) begin
      errors++; $display("FAIL expire_at_48 got=%h want=%h", obs(), {4'd0, 4'd0, 3'b011});
    end
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      if (tif.time_up) pulses++;
      checks++;
      if (obs() !== {4'd0, 4'd0, 3'b001}) begin
        errors++; $display("FAIL expired_hold got=%h want=%h", obs(), {4'd0, 4'd0, 3'b001});
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL time_up_count got=%0d want=1", pulses);
    end
  endtask
  task automatic test_pause();
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0);
      checks++;
      if (obs() !== {4'd1, 4'd2, 3'b000}) begin
        errors++; $display("FAIL paused_hold got=%h want=%h", obs(), {4'd1, 4'd2, 3'b000});
      end
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    checks++;
    if (obs() !== {4'd1, 4'd2, 3'b100}) begin
      errors++; $display("FAIL pause_resume_13 got=%h want=%h", obs(), {4'd1, 4'd2, 3'b100});
    end
    cyc(0, 0, 0);
    checks++;
    if (obs() !== {4'd1, 4'd1, 3'b100}) begin
      errors++; $display("FAIL pause_resume_14 got=%h want=%h", obs(), {4'd1, 4'd1, 3'b100});
    end
  endtask
  task automatic test_penalty();
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    checks++;
    if (obs() !== {4'd0, 4'd9, 3'b100}) begin
      errors++; $display("FAIL penalty_12 got=%h want=%h", obs(), {4'd0, 4'd9, 3'b100});
    end
    cyc(1, 0, 0);
    repeat (11) cyc(0, 0, 0);
    cyc(0, 0, 1);
    checks++;
    if (obs() !== {4'd0, 4'd6, 3'b100}) begin
      errors++; $display("FAIL penalty_tick got=%h want=%h", obs(), {4'd0, 4'd6, 3'b100});
    end
    repeat (16) cyc(0, 0, 0);
    cyc(0, 0, 1);
    checks++;
    if (obs() !== {4'd0, 4'd0, 3'b011}) begin
      errors++; $display("FAIL penalty_saturate got=%h want=%h", obs(), {4'd0, 4'd0, 3'b011});
    end
  endtask
  task automatic test_restart();
    cyc(1, 0, 0);
    repeat (22) cyc(0, 0, 0);
    checks++;
    if (obs() !== {4'd0, 4'd7, 3'b100}) begin
      errors++; $display("FAIL restart_pre got=%h want=%h", obs(), {4'd0, 4'd7, 3'b100});
    end
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    checks++;
    if (obs() !== {4'd1, 4'd2, 3'b100}) begin
      errors++; $display("FAIL restart_reload got=%h want=%h", obs(), {4'd1, 4'd2, 3'b100});
    end
    cyc(0, 0, 0);
    checks++;
    if (obs() !== {4'd1, 4'd1, 3'b100}) begin
      errors++; $display("FAIL restart_tick got=%h want=%h", obs(), {4'd1, 4'd1, 3'b100});
    end
    repeat (44) cyc(0, 0, 0);
    checks++;
    if (obs() !== {4'd0, 4'd0, 3'b011}) begin
      errors++; $display("FAIL restart_expire got=%h want=%h", obs(), {4'd0, 4'd0, 3'b011});
    end
    cyc(1, 0, 0);
    checks++;
    if (obs() !== {4'd1, 4'd2, 3'b100}) begin
      errors++; $display("FAIL start_from_expired got=%h want=%h", obs(), {4'd1, 4'd2, 3'b100});
    end
  endtask
  task automatic test_async_reset();
    cyc(1, 0, 0);
    repeat (6) cyc(0, 0, 0);
    #3 resetN = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== {4'd1, 4'd2, 3'b000}) begin
      errors++; $display("FAIL async_reset got=%h want=%h", obs(), {4'd1, 4'd2, 3'b000});
    end
    repeat (2) @(posedge clk);
    #2 resetN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0);
      checks++;
      if (obs() !== {4'd1, 4'd2, 3'b000}) begin
        errors++; $display("FAIL post_reset_idle got=%h want=%h", obs(), {4'd1, 4'd2, 3'b000});
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(39) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random_cycle_%0d got=%h want=%h", i, obs(), expv());
      end
    end
  endtask
  initial begin
    test_reset();
    test_countdown();
    test_expire();
    test_pause();
    test_penalty();
    test_restart();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
